// File: rtl/booth_iter_mul_if.sv
// booth_iter_mul_if: operand/product valid-ready bus of the iterative Booth multiplier
interface booth_iter_mul_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mcand;
  logic [15:0] in_mplier;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_product;
  logic        busy;
  modport master (output in_valid, in_mcand, in_mplier, out_ready,
                  input  in_ready, out_valid, out_product, busy);
  modport slave  (input  in_valid, in_mcand, in_mplier, out_ready,
                  output in_ready, out_valid, out_product, busy);
endinterface

// File: rtl/booth_iter_mul.sv
// booth_iter_mul: signed 16x16 multiplier, one radix-4 Booth digit per cycle
module booth_iter_mul #(
  parameter bit EARLY_TERM = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  booth_iter_mul_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state, state_n;
  logic [15:0] mcand_q, mplier_q, rest;
  logic [2:0]  i, dig;
  logic [31:0] acc, acc_n;
  logic [16:0] pp;
  logic        x1, x2, neg1, neg2, ovf, last;
  always_comb begin
    dig   = 3'({mplier_q, 1'b0} >> {i, 1'b0});
    x1    = dig == 3'b001 || dig == 3'b010;
    x2    = dig == 3'b011;
    neg2  = dig == 3'b100;
    neg1  = dig == 3'b101 || dig == 3'b110;
    pp    = x1 ? {mcand_q[15], mcand_q} : x2 ? {mcand_q, 1'b0} :
            neg1 ? -{mcand_q[15], mcand_q} : neg2 ? -{mcand_q, 1'b0} : '0;
    // -2 * -32768 = +65536 wraps to 17'h10000; flip the extension bit to restore it
    ovf   = neg2 && mcand_q == 16'h8000;
    acc_n = acc + ({{15{pp[16] ^ ovf}}, pp} << {i, 1'b0});
    rest  = 16'($signed(mplier_q) >>> ({1'b0, i, 1'b0} + 4'd1));
    last  = i == 3'd7 || (EARLY_TERM && (rest == '0 || rest == '1));
    state_n = state == IDLE ? (bus.in_valid ? BUSY : IDLE) :
              state == BUSY ? (last ? DONE : BUSY) :
              (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      i        <= '0;
      acc      <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      mcand_q  <= bus.in_mcand;
      mplier_q <= bus.in_mplier;
      i        <= '0;
      acc      <= '0;
    end else if (state == BUSY) begin
      acc <= acc_n;
      i   <= i + 3'd1;
    end
  assign bus.in_ready    = state == IDLE;
  assign bus.out_valid   = state == DONE;
  assign bus.busy        = state == BUSY;
  assign bus.out_product = acc;
endmodule

// File: doc/booth_iter_mul.md
# booth_iter_mul

Sequential signed 16x16 multiplier that time-shares a single radix-4 Booth partial-product unit across eight digit cycles.
- Each cycle it Booth-encodes one multiplier digit into the unit's X1/X2/NEG1/NEG2 selects and feeds the held multiplicand.
- It adds the returned 17-bit partial product, shifted by two bits per digit, into a 32-bit accumulator.
- It is the area-optimised alternative to the fully parallel partial-product array, with a valid/ready handshake on both sides.

## Interface
Parameters:
- EARLY_TERM, default 1: when 1, stop as soon as all remaining Booth digits are zero; when 0, always run 8 digit cycles.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- in_mcand  in  16  multiplicand, signed two's complement.
- in_mplier  in  16  multiplier, signed two's complement.
- out_valid  out  1  product valid; high only in DONE.
- out_ready  in  1  consumer accepts product.
- out_product  out  32  signed product; held stable while out_valid=1.
- busy  out  1  high in BUSY.

## Operation
Storage:
- Registers: state, mcand_q[15:0], mplier_q[15:0], digit index i[2:0], acc[31:0].

Booth digit i:
- The digit is formed from (b[2i+1], b[2i], b[2i-1]) of mplier_q, with b[-1]=0.
- 000 and 111 give 0: all selects low.
- 001 and 010 give +1: X1.
- 011 gives +2: X2.
- 100 gives -2: NEG2.
- 101 and 110 give -1: NEG1.
- Exactly one select is high, or none.

Partial product:
- The PP unit returns the 17-bit exact result d*mcand_q, including the two's-complement negate.
- The block sign-extends PP to 32 bits using extension bit e = PP[16] XOR ovf.
- ovf = NEG2 AND (mcand_q == 16'h8000). This corrects the single case +65536, which does not fit in 17 bits.

Accumulation:
- Each BUSY cycle: acc <= acc + (sext32(PP) << 2i), modulo 2^32.
- The final acc equals the exact signed product for all 2^32 operand pairs.

State machine:
- IDLE:
  - in_ready=1.
  - On in_valid: capture operands, acc<=0, i<=0, go to BUSY.
- BUSY:
  - Process digit i.
  - If i==7, or (EARLY_TERM==1 and mplier_q[15:2i+1] all equal), go to DONE with the updated acc. Otherwise i<=i+1.
  - in_valid is ignored.
- DONE:
  - out_valid=1, out_product=acc.
  - On out_ready, go to IDLE.
  - No new accept on the same edge.

## Timing
- Reset values: state=IDLE, acc=0, i=0, operand registers 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_product=0.
- in_ready, out_valid and busy are decoded from registered state only; no input-to-output combinational path.
- Accept edge to first out_valid cycle: N+1 edges, where N is the number of BUSY cycles.
  - EARLY_TERM=0: N=8.
  - EARLY_TERM=1: N = 1 + index of the last non-zero digit, in 1..8. Digit 0 is always processed.
- Throughput: one product per N+2 cycles with out_ready held high. The DONE cycle and the IDLE cycle are each one cycle.
- Backpressure: DONE holds indefinitely; out_product must not change while out_valid=1 and out_ready=0.
- Reset asserted in any state returns immediately to the reset values and discards the in-flight operation. There is no partial output.
- Operand bus changes while BUSY or DONE have no effect.

## Test plan
- EARLY_TERM=0, accept 3 x 5 -> out_valid rises exactly 9 edges after the accept; out_product=32'd15; busy high for 8 cycles.
- EARLY_TERM=0, accept 16'h8000 x 16'h8000 -> out_product=32'h4000_0000. Exercises the NEG2/ovf case at digit 7.
- EARLY_TERM=1, accept 1234 x 1 -> BUSY for 1 cycle, out_product=32'd1234.
  - Same block, accept 1234 x -1 -> BUSY for 1 cycle, out_product=32'hFFFF_FB2E (-1234).
- out_ready held low 20 cycles in DONE for -7 x 9 -> out_valid and out_product=32'hFFFF_FFC1 stable throughout; in_ready=0 throughout; one transfer on release, then IDLE.
- rst_n pulsed low during the 4th BUSY cycle of 100 x 200 -> outputs reach reset values asynchronously. The next accepted 2 x 3 yields 6 with no residue.
- Random regression: 10^5 random operands plus all corner pairs from {0, 1, -1, 32767, -32768}, with random out_ready, under both parameter values -> every product matches the signed reference; latency matches the formula above.
